// File: rtl/ahb5_rst_pkg_p.sv
// rtl/ahb5_rst_pkg_p.sv - shared types and defaults for the AHB5 reset sequencer
package ahb5_rst_pkg_p;

    typedef enum logic [1:0] {
        ASSERT,
        HOLD,
        RELEASE,
        DONE
    } ahb5_rst_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_EXT  = 2'd1,
        CAUSE_SW   = 2'd2
    } ahb5_rst_cause_e;

    localparam int DEF_NUM_CH         = 4;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_HOLD_CYCLES    = 8;
    localparam int DEF_STAGGER_CYCLES = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ahb5_rst_sync.sv
// rtl/ahb5_rst_sync.sv - async-assert / sync-deassert reset synchroniser
module ahb5_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rise
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b1};
        end
    end

    // High in the cycle before the chain output first goes high, so the
    // consumer can act on the same edge the synchronised reset releases.
    assign rise = chain[STAGES-2] & ~chain[STAGES-1];

endmodule

// File: rtl/ahb5_rst_sequencer.sv
// rtl/ahb5_rst_sequencer.sv - staged per-channel reset sequencer with software reset
module ahb5_rst_sequencer
    import ahb5_rst_pkg_p::*;
#(
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES
) (
    input  logic              AT_Hclk_l,
    input  logic              AT_HResetn_l,
    input  logic              sw_rst_req_i,
    input  logic [NUM_CH-1:0] ch_mask_i,
    output logic [NUM_CH-1:0] rst_n_o,
    output logic              rst_done_o,
    output logic              busy_o,
    output logic [1:0]        rst_cause_o
);

    localparam int CNT_W = $clog2(max2(HOLD_CYCLES, STAGGER_CYCLES) + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);

    ahb5_rst_state_e state_q, state_n;
    ahb5_rst_cause_e cause_q, cause_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [NUM_CH-1:0] pend_q, pend_n;
    logic [NUM_CH-1:0] rst_n_q, rst_n_n;
    logic [NUM_CH-1:0] lowest, remain;
    logic              done_q, done_n;
    logic              busy_q, busy_n;
    logic              sync_rise;

    ahb5_rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (AT_Hclk_l),
        .rst_n (AT_HResetn_l),
        .rise  (sync_rise)
    );

    // Lowest still-pending channel; unmasked indices are never pending, so
    // they are skipped without costing a stagger slot.
    assign lowest = pend_q & (~pend_q + NUM_CH'(1));
    assign remain = pend_q & ~lowest;

    always_comb begin
        state_n = state_q;
        cause_n = cause_q;
        cnt_n   = cnt_q;
        pend_n  = pend_q;
        rst_n_n = rst_n_q;
        case (state_q)
            ASSERT: begin
                if (sync_rise) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                    pend_n  = '1;
                end
            end
            HOLD, RELEASE: begin
                if (cnt_q == ((state_q == HOLD) ? HOLD_LAST : STAG_LAST)) begin
                    rst_n_n = rst_n_q | lowest;
                    pend_n  = remain;
                    cnt_n   = '0;
                    state_n = (remain == '0) ? DONE : RELEASE;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (sw_rst_req_i && (ch_mask_i != '0)) begin
                    pend_n  = ch_mask_i;
                    rst_n_n = rst_n_q & ~ch_mask_i;
                    cnt_n   = '0;
                    state_n = HOLD;
                    cause_n = CAUSE_SW;
                end
            end
            default: state_n = ASSERT;
        endcase
        done_n = (state_q == DONE) && (state_n == DONE);
        busy_n = !done_n;
    end

    always_ff @(posedge AT_Hclk_l or negedge AT_HResetn_l) begin
        if (!AT_HResetn_l) begin
            state_q <= ASSERT;
            cause_q <= CAUSE_EXT;
            cnt_q   <= '0;
            pend_q  <= '1;
            rst_n_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_n;
            cause_q <= cause_n;
            cnt_q   <= cnt_n;
            pend_q  <= pend_n;
            rst_n_q <= rst_n_n;
            done_q  <= done_n;
            busy_q  <= busy_n;
        end
    end

    assign rst_n_o     = rst_n_q;
    assign rst_done_o  = done_q;
    assign busy_o      = busy_q;
    assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_ahb5_rst_sequencer.sv
// tb/tb_ahb5_rst_sequencer.sv - directed checks for ahb5_rst_sequencer
module tb_ahb5_rst_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sw_req = 1'b0;
    logic [3:0] mask = 4'b0000;
    logic [3:0] rst_out;
    logic       done;
    logic       busy;
    logic [1:0] cause;

    logic       rst2_n = 1'b1;
    logic       sw_req2 = 1'b0;
    logic [0:0] mask2 = 1'b0;
    logic [0:0] rst_out2;
    logic       done2;
    logic       busy2;
    logic [1:0] cause2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahb5_rst_sequencer dut (
        .AT_Hclk_l    (clk),
        .AT_HResetn_l (rst_n),
        .sw_rst_req_i (sw_req),
        .ch_mask_i    (mask),
        .rst_n_o      (rst_out),
        .rst_done_o   (done),
        .busy_o       (busy),
        .rst_cause_o  (cause)
    );

    ahb5_rst_sequencer #(
        .NUM_CH(1), .SYNC_STAGES(3), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)
    ) dut1 (
        .AT_Hclk_l    (clk),
        .AT_HResetn_l (rst2_n),
        .sw_rst_req_i (sw_req2),
        .ch_mask_i    (mask2),
        .rst_n_o      (rst_out2),
        .rst_done_o   (done2),
        .busy_o       (busy2),
        .rst_cause_o  (cause2)
    );

    typedef struct {
        int         t;
        logic [3:0] r;
        logic       d;
        logic       b;
        logic [1:0] c;
        logic       r2;
        logic       d2;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [3:0] r, input logic d,
                       input logic b, input logic [1:0] c);
        checks++;
        if ({rst_out, done, busy, cause} !== {r, d, b, c}) begin
            errors++;
            $display("FAIL %s @%0t: rst_n=%b done=%b busy=%b cause=%0d, want rst_n=%b done=%b busy=%b cause=%0d",
                     name, $time, rst_out, done, busy, cause, r, d, b, c);
        end
    endtask

    task automatic chk2(input string name, input logic r2, input logic d2);
        checks++;
        if ({rst_out2, done2} !== {r2, d2}) begin
            errors++;
            $display("FAIL %s @%0t: ch1 rst_n=%b done=%b, want rst_n=%b done=%b",
                     name, $time, rst_out2, done2, r2, d2);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tbl.push_back('{2,   4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{26,  4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{36,  4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{46,  4'b0000, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{56,  4'b0000, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1});
        tbl.push_back('{104, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1});
        tbl.push_back('{106, 4'b0001, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1});
        tbl.push_back('{144, 4'b0001, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1});
        tbl.push_back('{146, 4'b0011, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1});
        tbl.push_back('{184, 4'b0011, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1});
        tbl.push_back('{186, 4'b0111, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1});
        tbl.push_back('{226, 4'b1111, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1});
        tbl.push_back('{236, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1});

        #1 rst_n = 1'b0; rst2_n = 1'b0;
        fork
            begin
                #9 rst_n = 1'b1; rst2_n = 1'b1;
            end
        join_none

        // Power-on sequence, sampled at absolute times one ns after edges
        foreach (tbl[i]) begin
            #(tbl[i].t - $time);
            chk($sformatf("poweron_t%0d", tbl[i].t), tbl[i].r, tbl[i].d, tbl[i].b, tbl[i].c);
            chk2($sformatf("one_ch_t%0d", tbl[i].t), tbl[i].r2, tbl[i].d2);
        end

        // Software reset of ch1/ch3; mask change after latch must be ignored
        sw_req = 1'b1; mask = 4'b1010;
        tick(1);
        sw_req = 1'b0; mask = 4'b1111;
        chk("sw_latch", 4'b0101, 1'b0, 1'b1, 2'd2);
        tick(7);
        chk("sw_hold_end", 4'b0101, 1'b0, 1'b1, 2'd2);
        tick(1);
        chk("sw_ch1_rel", 4'b0111, 1'b0, 1'b1, 2'd2);
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        chk("sw_req_in_release", 4'b0111, 1'b0, 1'b1, 2'd2);
        tick(2);
        chk("sw_ch3_wait", 4'b0111, 1'b0, 1'b1, 2'd2);
        tick(1);
        chk("sw_ch3_rel", 4'b1111, 1'b0, 1'b1, 2'd2);
        tick(1);
        chk("sw_done", 4'b1111, 1'b1, 1'b0, 2'd2);

        // Zero mask in DONE is a no-op
        sw_req = 1'b1; mask = 4'b0000;
        tick(1);
        sw_req = 1'b0;
        chk("mask0_a", 4'b1111, 1'b1, 1'b0, 2'd2);
        tick(1);
        chk("mask0_b", 4'b1111, 1'b1, 1'b0, 2'd2);

        // External reset glitch in the middle of a software sequence
        sw_req = 1'b1; mask = 4'b0011;
        tick(1);
        sw_req = 1'b0;
        chk("sw2_latch", 4'b1100, 1'b0, 1'b1, 2'd2);
        tick(3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("glitch_async", 4'b0000, 1'b0, 1'b1, 2'd1);
        #2 rst_n = 1'b1;
        tick(2);
        chk("rerun_at_s", 4'b0000, 1'b0, 1'b1, 2'd1);
        tick(7);
        chk("rerun_hold_end", 4'b0000, 1'b0, 1'b1, 2'd1);
        tick(1);
        chk("rerun_ch0", 4'b0001, 1'b0, 1'b1, 2'd1);
        tick(12);
        chk("rerun_ch3", 4'b1111, 1'b0, 1'b1, 2'd1);
        tick(1);
        chk("rerun_done", 4'b1111, 1'b1, 1'b0, 2'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb5_rst_sequencer.md
Name: ahb5_rst_sequencer

Overview:
- Parametrised reset sequencer for the AHB5 environment, replacing the single fixed global reset with NUM_CH staged, synchronised, per-channel resets.
- Sits between the global clock/reset source and the interface, DUT and peripheral-model reset inputs.
- Adds synchronised deassertion, programmable hold time, staggered per-channel release, masked software reset, done status and reset-cause reporting.

Parameters:
- NUM_CH, 4, number of reset output channels (1..16).
- SYNC_STAGES, 2, reset-deassert synchroniser depth (>=2).
- HOLD_CYCLES, 8, cycles all targeted channels stay asserted after synchronised release (>=1).
- STAGGER_CYCLES, 4, cycles between consecutive channel releases (>=1).
- CNT_W, $clog2(max(HOLD_CYCLES,STAGGER_CYCLES)+1), internal counter width (derived, not overridden).

Ports:
- AT_Hclk_l  input  1  system clock, rising edge.
- AT_HResetn_l  input  1  global reset, asynchronous, active-low.
- sw_rst_req_i  input  1  software reset request, single-cycle pulse.
- ch_mask_i  input  NUM_CH  channels targeted by a software reset; sampled with sw_rst_req_i.
- rst_n_o  output  NUM_CH  per-channel active-low resets.
- rst_done_o  output  1  high when all channels are released and the sequencer is idle.
- busy_o  output  1  high while any sequence is in progress.
- rst_cause_o  output  2  cause of last sequence: 0 none, 1 external, 2 software.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- AT_HResetn_l low: all rst_n_o=0, rst_done_o=0, busy_o=1, rst_cause_o=1, FSM=ASSERT, counters=0. All take effect immediately, without a clock.
- Deassertion passes through a SYNC_STAGES flop chain. Define S as the edge where the chain output first goes high: E0+(SYNC_STAGES-1) cycles, where E0 is the first rising edge that samples AT_HResetn_l high.
- FSM states: ASSERT, HOLD, RELEASE, DONE.
- ASSERT -> HOLD at S. The hold counter loads 0.
- HOLD counts HOLD_CYCLES cycles, then moves to RELEASE.
- External sequence timing:
  - rst_n_o[0] goes 1 at edge S+HOLD_CYCLES.
  - rst_n_o[k] goes 1 at edge S+HOLD_CYCLES+k*STAGGER_CYCLES.
  - Release is in ascending index order.
- RELEASE -> DONE on the edge the last targeted channel is released. rst_done_o=1 and busy_o=0 from the next edge.
- In DONE, sw_rst_req_i=1 with ch_mask_i!=0:
  - The next edge latches the mask and drives rst_n_o[i]=0 for every masked i.
  - Unmasked channels stay 1 throughout.
  - Same edge: rst_done_o=0, busy_o=1, rst_cause_o=2, FSM=HOLD.
- Software sequence timing:
  - HOLD lasts HOLD_CYCLES, as for the external sequence.
  - RELEASE releases only masked channels, in ascending index order, STAGGER_CYCLES apart.
  - Unmasked indices are skipped with zero delay. E.g. mask 4'b1010: ch1 at H, ch3 at H+STAGGER_CYCLES.
- sw_rst_req_i ignored outside DONE, and ignored when ch_mask_i==0. ch_mask_i changes after the latch edge have no effect.
- AT_HResetn_l asserting mid-sequence (any state) immediately forces the full reset values. Any software sequence in progress is abandoned; rst_cause_o becomes 1.
- All outputs are registered; no combinational path from inputs to outputs except the asynchronous reset.
- NUM_CH=1: RELEASE lasts a single edge (channel 0 only).

Decomposition:
- Shared package ahb5_rst_pkg_p holds:
  - state enum ahb5_rst_state_e {ASSERT, HOLD, RELEASE, DONE};
  - cause enum ahb5_rst_cause_e {CAUSE_NONE=0, CAUSE_EXT=1, CAUSE_SW=2};
  - default parameter constants.
- One sub-module, ahb5_rst_sync: SYNC_STAGES-deep async-assert/sync-deassert synchroniser.

Test Plan:
- Power-on, defaults, 10 ns clock, AT_HResetn_l released at 10 ns (rising edges at 5/15/25 ns):
  - S=25 ns;
  - rst_n_o[0..3] rise at 105/145/185/225 ns;
  - rst_done_o=1 at 235 ns;
  - rst_cause_o=1.
- Software reset, mask 4'b1010 pulsed in DONE:
  - ch1 and ch3 go 0 on the next edge, while ch0 and ch2 stay 1;
  - ch1 released 8 cycles later, ch3 4 cycles after ch1;
  - rst_cause_o=2.
- sw_rst_req_i during RELEASE, and sw_rst_req_i with mask 0 in DONE -> no change to any output.
- AT_HResetn_l low for 3 ns during a software sequence, between edges:
  - all rst_n_o=0 immediately;
  - full external sequence restarts;
  - rst_cause_o=1.
- NUM_CH=1, HOLD_CYCLES=1, STAGGER_CYCLES=1, SYNC_STAGES=3 -> rst_n_o[0] rises at S+1, where S=E0+2 edges; rst_done_o one edge later.
